// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three per-source result FIFOs arbitrated onto one registered common data bus.
// Define CDB_FIXED_PRIO_EN for fixed MUL > LSU > ALU priority; otherwise round-robin is used.
module cdb_arbiter #(
  parameter int DATA_W     = 16,
  parameter int PRF_TAG_W  = 5,
  parameter int ROB_TAG_W  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 valid_alu,
  input  logic                 valid_mul,
  input  logic                 valid_lsu,
  input  logic [DATA_W-1:0]    result_alu,
  input  logic [DATA_W-1:0]    result_mul,
  input  logic [DATA_W-1:0]    result_lsu,
  input  logic [PRF_TAG_W-1:0] tag_PRF_alu,
  input  logic [PRF_TAG_W-1:0] tag_PRF_mul,
  input  logic [PRF_TAG_W-1:0] tag_PRF_lsu,
  input  logic [ROB_TAG_W-1:0] tag_ROB_alu,
  input  logic [ROB_TAG_W-1:0] tag_ROB_mul,
  input  logic [ROB_TAG_W-1:0] tag_ROB_lsu,
  output logic                 freeze_back,
  output logic                 cdb_valid,
  output logic [DATA_W-1:0]    cdb_result,
  output logic [PRF_TAG_W-1:0] cdb_tag_PRF,
  output logic [ROB_TAG_W-1:0] cdb_tag_ROB,
  output logic [1:0]           cdb_src
);

  localparam int ENTRY_W = DATA_W + PRF_TAG_W + ROB_TAG_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [2:0]              in_valid;
  logic [2:0][ENTRY_W-1:0] in_entry;

  logic [2:0][FIFO_DEPTH-1:0][ENTRY_W-1:0] mem_q, mem_d;
  logic [2:0][PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0][PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                    freeze_q, freeze_d;

  logic                    cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0]       cdb_result_q, cdb_result_d;
  logic [PRF_TAG_W-1:0]    cdb_tag_PRF_q, cdb_tag_PRF_d;
  logic [ROB_TAG_W-1:0]    cdb_tag_ROB_q, cdb_tag_ROB_d;
  logic [1:0]              cdb_src_q, cdb_src_d;

  logic [2:0]              not_empty;
  logic [2:0]              full;
  logic [2:0]              push;
  logic [2:0]              pop;
  logic                    grant_valid;
  logic [1:0]              grant_idx;

  assign in_valid    = {valid_lsu, valid_mul, valid_alu};
  assign in_entry[0] = {result_alu, tag_PRF_alu, tag_ROB_alu};
  assign in_entry[1] = {result_mul, tag_PRF_mul, tag_ROB_mul};
  assign in_entry[2] = {result_lsu, tag_PRF_lsu, tag_ROB_lsu};

  always_comb begin
    not_empty = '0;
    full      = '0;
    for (int i = 0; i < 3; i++) begin
      not_empty[i] = (cnt_q[i] != '0);
      full[i]      = (cnt_q[i] == FULL_CNT);
    end
  end

`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    grant_valid = |not_empty;
    grant_idx   = 2'd0;
    if (not_empty[1])      grant_idx = 2'd1;
    else if (not_empty[2]) grant_idx = 2'd2;
  end
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] cand;

  // Scan the three sources starting at rr_ptr, wrapping modulo 3.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = '0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!grant_valid && not_empty[cand[1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid && !flush) rr_ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    cdb_valid_d   = 1'b0;
    cdb_result_d  = cdb_result_q;
    cdb_tag_PRF_d = cdb_tag_PRF_q;
    cdb_tag_ROB_d = cdb_tag_ROB_q;
    cdb_src_d     = cdb_src_q;
    push          = '0;
    pop           = '0;
    freeze_d      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push[i] = in_valid[i] && !freeze_q && !flush;
      pop[i]  = grant_valid && (grant_idx == 2'(i)) && !flush;
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) begin
          mem_d[i][wr_ptr_q[i]] = in_entry[i];
          wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
        end
        if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (grant_valid) begin
        cdb_valid_d = 1'b1;
        {cdb_result_d, cdb_tag_PRF_d, cdb_tag_ROB_d} = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        cdb_src_d   = grant_idx;
      end
    end
    // Stall one cycle ahead so a FIFO reaching full never sees another push.
    for (int i = 0; i < 3; i++) begin
      if (cnt_d[i] == FULL_CNT) freeze_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      freeze_q      <= 1'b0;
      cdb_valid_q   <= 1'b0;
      cdb_result_q  <= '0;
      cdb_tag_PRF_q <= '0;
      cdb_tag_ROB_q <= '0;
      cdb_src_q     <= '0;
    end else begin
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      freeze_q      <= freeze_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_result_q  <= cdb_result_d;
      cdb_tag_PRF_q <= cdb_tag_PRF_d;
      cdb_tag_ROB_q <= cdb_tag_ROB_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) ((push & full) == 3'b000));

  assign freeze_back = freeze_q;
  assign cdb_valid   = cdb_valid_q;
  assign cdb_result  = cdb_result_q;
  assign cdb_tag_PRF = cdb_tag_PRF_q;
  assign cdb_tag_ROB = cdb_tag_ROB_q;
  assign cdb_src     = cdb_src_q;

endmodule
